// File: rtl/display_pkg.sv
// Shared constants, types and the digit-correction helper for the BCD display
// sequencer.
package display_pkg;

    localparam int DIGITS     = 6;
    localparam int ACC_DIGITS = 7;
    localparam int BCD_W      = 4;
    localparam int ACC_W      = ACC_DIGITS * BCD_W;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t ADD3_THRESH = 4'd5;
    localparam bcd_digit_t ADD3_INC    = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    // Pre-shift correction so that a doubled digit carries correctly into the next one.
    function automatic bcd_digit_t add3(input bcd_digit_t d);
        return (d >= ADD3_THRESH) ? bcd_digit_t'(d + ADD3_INC) : d;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// One BCD digit of the double-dabble correction stage: adds 3 when the digit is 5 or more.
module bcd_add3_cell
    import display_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit
);

    assign o_digit = add3(i_digit);

endmodule

// File: rtl/display_bcd_sequencer.sv
// Arbitrates two display-update requesters and converts the granted binary value
// to six BCD digits with a leading-zero blank mask and an overflow flag.
module display_bcd_sequencer
    import display_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_i,
    input  logic [WIDTH-1:0] value0_i,
    input  logic [WIDTH-1:0] value1_i,
    input  logic             freeze_i,
    output logic [1:0]       ack_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             src_o,
    output logic [23:0]      bcd_o,
    output logic [5:0]       blank_o,
    output logic             overflow_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam int DISP_W = DIGITS * BCD_W;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]       r_sr;
    logic [ACC_W-1:0]       r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_last_grant;
    logic [1:0]             r_ack;
    logic                   r_done;
    logic                   r_src;
    logic [DISP_W-1:0]      r_bcd;
    logic [DIGITS-1:0]      r_blank;
    logic                   r_ovf;

    logic                   w_accept;
    logic                   w_grant;
    logic [ACC_W-1:0]       w_acc_adj;
    logic [ACC_W+WIDTH-1:0] w_shifted;
    logic                   w_ovf;
    logic [DIGITS-1:1]      w_digit_zero;
    logic [DIGITS-1:0]      w_blank;
    logic                   w_unused_top;

    // Round-robin: on a tie the requester that did not win last time is granted.
    always_comb begin
        w_grant = 1'b0;
        case (req_i)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;
            default: w_grant = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!freeze_i && (req_i != 2'b00)) begin
                    w_accept     = 1'b1;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                if (r_cnt == LAST_STEP) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < ACC_DIGITS; gi++) begin : g_add3
            bcd_add3_cell u_cell (
                .i_digit(r_acc[gi*BCD_W +: BCD_W]),
                .o_digit(w_acc_adj[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // The top accumulator bit is shifted out; it is always 0 for WIDTH <= 23.
    assign w_unused_top = w_acc_adj[ACC_W-1];
    assign w_shifted    = {w_acc_adj[ACC_W-2:0], r_sr, 1'b0};

    assign w_ovf = (r_acc[ACC_W-1:DISP_W] != '0);

    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign w_digit_zero[gi] = (r_acc[gi*BCD_W +: BCD_W] == '0);
            assign w_blank[gi]      = ~w_ovf & (&w_digit_zero[DIGITS-1:gi]);
        end
    endgenerate
    assign w_blank[0] = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr         <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_ack        <= 2'b00;
            r_done       <= 1'b0;
            r_src        <= 1'b0;
            r_bcd        <= '0;
            r_blank      <= 6'b111110;
            r_ovf        <= 1'b0;
        end else begin
            r_ack  <= 2'b00;
            r_done <= 1'b0;
            if (w_accept) begin
                r_sr         <= w_grant ? value1_i : value0_i;
                r_acc        <= '0;
                r_cnt        <= '0;
                r_last_grant <= w_grant;
                r_ack        <= {w_grant, ~w_grant};
            end else if (r_state == CONV) begin
                r_acc <= w_shifted[ACC_W+WIDTH-1 -: ACC_W];
                r_sr  <= w_shifted[WIDTH-1:0];
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == COMMIT) begin
                r_bcd   <= r_acc[DISP_W-1:0];
                r_ovf   <= w_ovf;
                r_blank <= w_blank;
                r_src   <= r_last_grant;
                r_done  <= 1'b1;
            end
        end
    end

    assign ack_o      = r_ack;
    assign busy_o     = (r_state != IDLE);
    assign done_o     = r_done;
    assign src_o      = r_src;
    assign bcd_o      = r_bcd;
    assign blank_o    = r_blank;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_display_bcd_sequencer.sv
// Directed bench for display_bcd_sequencer: vector table plus hand-written
// reset, tie, freeze and mid-conversion reset sequences.
module tb_display_bcd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_i = 2'b00;
    logic [19:0] value0_i = '0;
    logic [19:0] value1_i = '0;
    logic        freeze_i = 1'b0;
    logic [1:0]  ack_o;
    logic        busy_o;
    logic        done_o;
    logic        src_o;
    logic [23:0] bcd_o;
    logic [5:0]  blank_o;
    logic        overflow_o;

    display_bcd_sequencer #(.WIDTH(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .value0_i  (value0_i),
        .value1_i  (value1_i),
        .freeze_i  (freeze_i),
        .ack_o     (ack_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .src_o     (src_o),
        .bcd_o     (bcd_o),
        .blank_o   (blank_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [19:0] v0;
        logic [19:0] v1;
        logic        exp_src;
        logic [23:0] exp_bcd;
        logic [5:0]  exp_blank;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ack_o != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s ack timeout: got no ack expected ack within 50 cycles", name);
        end
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (done_o) begin
                cyc = i;
                break;
            end
        end
        check({name, " latency"}, 32'(cyc), 32'd21);
    endtask

    task automatic check_commit(input string name, input logic [23:0] bcd, input logic [5:0] blank,
                                input logic ovf, input logic src);
        check({name, " bcd"}, 32'(bcd_o), 32'(bcd));
        check({name, " blank"}, 32'(blank_o), 32'(blank));
        check({name, " ovf"}, 32'(overflow_o), 32'(ovf));
        check({name, " src"}, 32'(src_o), 32'(src));
        $display("txn %s: bcd=%h blank=%b ovf=%b src=%0d", name, bcd_o, blank_o, overflow_o, src_o);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        vecs[0] = '{2'b01, 20'd123456,  20'd0,       1'b0, 24'h123456, 6'b000000, 1'b0};
        vecs[1] = '{2'b10, 20'd0,       20'd1048575, 1'b1, 24'h048575, 6'b000000, 1'b1};
        vecs[2] = '{2'b01, 20'd0,       20'd0,       1'b0, 24'h000000, 6'b111110, 1'b0};
        vecs[3] = '{2'b10, 20'd0,       20'd999999,  1'b1, 24'h999999, 6'b000000, 1'b0};
        vecs[4] = '{2'b01, 20'd1000000, 20'd0,       1'b0, 24'h000000, 6'b000000, 1'b1};
        vecs[5] = '{2'b10, 20'd0,       20'd42,      1'b1, 24'h000042, 6'b111100, 1'b0};
        vecs[6] = '{2'b01, 20'd100000,  20'd0,       1'b0, 24'h100000, 6'b000000, 1'b0};
        vecs[7] = '{2'b10, 20'd0,       20'd5,       1'b1, 24'h000005, 6'b111110, 1'b0};

        // Reset state, idle with no requests
        tick();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done_o || busy_o || ack_o != 2'b00) cnt++;
        end
        check("idle activity", 32'(cnt), 32'd0);
        check_commit("reset", 24'h000000, 6'b111110, 1'b0, 1'b0);

        // Tie right after reset: requester 0 first, then requester 1 without re-request
        value0_i = 20'd7;
        value1_i = 20'd900;
        req_i = 2'b11;
        wait_ack("tie1");
        check("tie1 ack", 32'(ack_o), 32'h1);
        req_i = 2'b10;
        wait_done("tie1");
        check_commit("tie1", 24'h000007, 6'b111110, 1'b0, 1'b0);
        tick();
        check("tie2 ack", 32'(ack_o), 32'h2);
        check("tie1 done pulse", 32'(done_o), 32'd0);
        req_i = 2'b00;
        wait_done("tie2");
        check_commit("tie2", 24'h000900, 6'b111000, 1'b0, 1'b1);

        // Table-driven single-requester transactions
        for (int v = 0; v < 8; v++) begin
            value0_i = vecs[v].v0;
            value1_i = vecs[v].v1;
            req_i = vecs[v].req;
            wait_ack("vec");
            check("vec ack", 32'(ack_o), 32'(vecs[v].req));
            check("vec busy", 32'(busy_o), 32'd1);
            req_i = 2'b00;
            tick();
            check("vec ack pulse", 32'(ack_o), 32'd0);
            cnt = 1;
            while (!done_o && cnt < 100) begin
                tick();
                cnt++;
            end
            check("vec latency", 32'(cnt), 32'd21);
            check_commit("vec", vecs[v].exp_bcd, vecs[v].exp_blank, vecs[v].exp_ovf, vecs[v].exp_src);
            tick();
            check("vec done pulse", 32'(done_o), 32'd0);
            check("vec busy end", 32'(busy_o), 32'd0);
        end

        // Freeze blocks acceptance, release lets the held request in
        freeze_i = 1'b1;
        value0_i = 20'd654321;
        req_i = 2'b01;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_o != 2'b00 || busy_o) cnt++;
        end
        check("freeze activity", 32'(cnt), 32'd0);
        freeze_i = 1'b0;
        tick();
        check("unfreeze ack", 32'(ack_o), 32'h1);
        req_i = 2'b00;
        wait_done("unfreeze");
        check_commit("unfreeze", 24'h654321, 6'b000000, 1'b0, 1'b0);

        // Asynchronous reset in the 10th conversion cycle
        value0_i = 20'd77;
        req_i = 2'b01;
        wait_ack("prereset");
        for (int i = 0; i < 9; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_commit("async reset", 24'h000000, 6'b111110, 1'b0, 1'b0);
        check("async reset busy", 32'(busy_o), 32'd0);
        check("async reset ack", 32'(ack_o), 32'd0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done_o || busy_o) cnt++;
        end
        check("reset hold activity", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        wait_ack("post reset");
        check("post reset ack", 32'(ack_o), 32'h1);
        req_i = 2'b00;
        wait_done("post reset");
        check_commit("post reset", 24'h000077, 6'b111100, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_bcd_sequencer.md
Name: display_bcd_sequencer

Overview:
Sequential front end for the six-digit seven-segment display. It arbitrates between two result producers and converts the granted 20-bit binary value to BCD over multiple cycles using shift-add-3 (double dabble). This replaces a purely combinational divide-by-10 chain. The block holds the committed digits, a leading-zero blank mask and an overflow flag, and these outputs feed the per-digit seven-segment encoders.

Parameters:
WIDTH, 20, binary input width; legal range 4..23; sets the number of conversion cycles.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_i  in  2  per-requester display-update request; level, held until matching ack_o
value0_i  in  WIDTH  requester 0 value; stable while req_i[0] is high
value1_i  in  WIDTH  requester 1 value; stable while req_i[1] is high
freeze_i  in  1  when high, no new request is accepted; display holds
ack_o  out  2  one-cycle accept pulse to the granted requester
busy_o  out  1  high from accept until commit completes
done_o  out  1  one-cycle pulse when new digits become visible
src_o  out  1  requester whose value is currently displayed
bcd_o  out  24  six BCD digits; bits[3:0] are the least significant digit
blank_o  out  6  per-digit blank; bit0 is always 0
overflow_o  out  1  committed value exceeded 999999

Behaviour:
- Reset (asynchronous, any state, takes effect immediately):
  - state IDLE; bcd_o=0; blank_o=6'b111110; overflow_o=0; ack_o=0; done_o=0; busy_o=0; src_o=0.
  - RR pointer set so requester 0 wins the first tie.
  - Any in-flight conversion is discarded with no done_o.
- FSM states: IDLE -> CONV -> COMMIT -> IDLE.
- IDLE:
  - At an edge with freeze_i=0 and req_i!=0, grant one requester and capture its value into the shift register. Internal BCD accumulator (7 digits) is cleared and the counter is set to 0.
  - State goes to CONV. ack_o[g] and busy_o are high in the following cycle.
- Arbitration:
  - Single request wins.
  - Both requesting: the requester not granted last time wins (round-robin). The pointer updates on grant only.
- CONV, one step per edge, WIDTH edges total:
  - Every accumulator digit >=5 gets +3.
  - Then {accumulator, shift register} shifts left by 1.
  - After the WIDTH-th step, state goes to COMMIT.
- COMMIT, on its edge:
  - bcd_o = low 6 accumulator digits (value mod 1,000,000).
  - overflow_o = (digit 6 != 0).
  - src_o = g.
  - blank_o[k]=1 for k=1..5 when digit k and all higher displayed digits are 0 and overflow is 0. When overflow is set, blank_o=0.
  - State goes to IDLE. done_o is high next cycle; busy_o is low next cycle.
- Latency: accept at edge E, outputs and done_o valid after edge E+WIDTH+1. Earliest next accept is edge E+WIDTH+2.
- Requests arriving or held during CONV/COMMIT wait; they are not dropped.
- freeze_i only gates acceptance. A conversion in progress still completes and commits.
- A requester dropping req_i before ack is legal; it is simply not granted.
- bcd_o, blank_o, overflow_o and src_o change only at COMMIT or reset.
- Accumulator width is 28 bits (7 digits), which covers WIDTH<=23 without truncation.

Decomposition:
- Package display_pkg holds:
  - DIGITS=6 and ACC_DIGITS=7 constants;
  - BCD_W=4;
  - ADD3_THRESH=5;
  - state enum {IDLE, CONV, COMMIT};
  - bcd_digit_t typedef.
- Sub-module bcd_add3_cell: 4-bit combinational digit correction (+3 when >=5). It is instantiated ACC_DIGITS times inside display_bcd_sequencer.

Test Plan:
1. Reset released, no req -> bcd_o=0, blank_o=6'b111110, overflow_o=0, busy_o=0, done_o never pulses.
2. req_i=01, value0_i=123456 -> ack_o=01 one cycle. done_o pulses 21 cycles after the accept edge. bcd_o=24'h123456, blank_o=0, overflow_o=0, src_o=0.
3. req_i=10, value1_i=1048575 -> bcd_o=24'h048575, overflow_o=1, blank_o=0, src_o=1.
4. After reset, req_i=11 with value0_i=7, value1_i=900:
   - first commit: bcd_o=24'h000007, blank_o=6'b111110, src_o=0;
   - second commit follows without re-request: bcd_o=24'h000900, blank_o=6'b111000, src_o=1.
5. freeze_i=1 with req_i=01 held for 10 cycles -> no ack_o, busy_o=0. Drop freeze_i -> ack_o[0] in the cycle after the next edge.
6. rst_n low during the 10th CONV cycle -> all outputs return to reset values immediately and no done_o. After rst_n high with req still held -> re-accepted and committed normally.
